// File: rtl/spi_cmd_framer_pkg.sv
// Shared definitions for the SPI command framer: command field layout,
// frame length and FSM state encoding.
package spi_cmd_framer_pkg;

  localparam int CMD_W              = 8;
  localparam int CMD_MSB            = CMD_W - 1;
  localparam int DATAWORD_WIDTH_DEF = 16;
  localparam int FRAME_LEN_DEF      = CMD_W + DATAWORD_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_OVERRUN = 2'd2
  } state_t;

  // A frame is the command byte followed by the data field.
  function automatic int frame_len(input int dw);
    return CMD_W + dw;
  endfunction

endpackage

// File: rtl/spi_cmd_framer_if.sv
// SPI pins plus the parallel command/data result bus of the framer.
interface spi_cmd_framer_if
  import spi_cmd_framer_pkg::*;
#(
  parameter int DATAWORD_WIDTH = 16
);

  logic                      spi_sck;
  logic                      spi_cs_n;
  logic                      spi_mosi;
  logic                      spi_miso;
  logic [CMD_W-1:0]          cmd_word;
  logic [DATAWORD_WIDTH-1:0] data_word;
  logic                      cmd_valid;
  logic                      frame_err;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi,
    output spi_miso, cmd_word, data_word, cmd_valid, frame_err
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi,
    input  spi_miso, cmd_word, data_word, cmd_valid, frame_err
  );

endinterface

// File: rtl/spi_cmd_framer_sync.sv
// Multi-flop synchronizer for one asynchronous input bit (STAGES = 2..3).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_cmd_framer.sv
// SPI mode-0 slave that frames an 8-bit command plus a data word, flags
// malformed frames and echoes the previously accepted command on MISO.
module spi_cmd_framer
  import spi_cmd_framer_pkg::*;
#(
  parameter int DATAWORD_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_cmd_framer_if.slave  bus
);

  localparam int FRAME_LEN = frame_len(DATAWORD_WIDTH);
  // Counter holds FRAME_LEN+1 without wrapping.
  localparam int CNT_W = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  logic w_sck_s, w_cs_s, w_mosi_s;
  logic r_sck_d, r_cs_d;
  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

  state_t r_state, w_state_nxt;
  logic   w_start, w_shift_en, w_accept, w_reject, w_echo_adv;

  logic [FRAME_LEN-1:0]      r_shift;
  logic [CNT_W-1:0]          r_cnt;
  logic [CMD_W-1:0]          r_echo;
  logic [CMD_W-1:0]          r_cmd_word;
  logic [DATAWORD_WIDTH-1:0] r_data_word;
  logic                      r_cmd_valid;
  logic                      r_frame_err;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .i_d(bus.spi_sck),  .o_q(w_sck_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .i_d(bus.spi_cs_n), .o_q(w_cs_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .i_d(bus.spi_mosi), .o_q(w_mosi_s));

  // History flops for edge detection on synced sck and cs_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_d <= 1'b0;
      r_cs_d  <= 1'b0;
    end else begin
      r_sck_d <= w_sck_s;
      r_cs_d  <= w_cs_s;
    end
  end

  // Reset history of cs_n is 0, so a frame needs a genuine 1->0 after reset.
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and strobes; cs_n rise outranks a same-cycle sck rise.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_echo_adv  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          if (r_cnt == FRAME_LEN_C) w_accept = 1'b1;
          else                      w_reject = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_sck_rise) begin
            if (r_cnt == FRAME_LEN_C) w_state_nxt = ST_OVERRUN;
            else                      w_shift_en  = 1'b1;
          end
          w_echo_adv = w_sck_fall;
        end
      end
      ST_OVERRUN: begin
        if (w_cs_rise) begin
          w_reject    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, bit counter and MISO echo register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_echo  <= '0;
    end else if (w_start) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_echo  <= r_cmd_word;
    end else begin
      if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_LEN-2:0], w_mosi_s};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_echo_adv) r_echo <= {r_echo[CMD_W-2:0], 1'b0};
    end
  end

  // Result registers: words update together with the cmd_valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_word  <= '0;
      r_data_word <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= w_accept;
      r_frame_err <= w_reject;
      if (w_accept) begin
        r_cmd_word  <= r_shift[FRAME_LEN-1 -: CMD_W];
        r_data_word <= r_shift[DATAWORD_WIDTH-1:0];
      end
    end
  end

  assign bus.spi_miso  = r_echo[CMD_MSB];
  assign bus.cmd_word  = r_cmd_word;
  assign bus.data_word = r_data_word;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Directed bench for spi_cmd_framer: SCK at clk/8, frames built bit by bit.
module tb_spi_cmd_framer;
  import spi_cmd_framer_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   n_valid, n_err, n_both;

  spi_cmd_framer_if #(.DATAWORD_WIDTH(16)) bus ();

  spi_cmd_framer #(.DATAWORD_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.cmd_valid) n_valid++;
    if (bus.frame_err) n_err++;
    if (bus.cmd_valid && bus.frame_err) n_both++;
  end

  task automatic cs_start();
    bus.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic miso);
    bus.spi_mosi = b;
    repeat (4) @(negedge clk);
    miso = bus.spi_miso;
    bus.spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_sck = 1'b0;
  endtask

  // Sends the top n bits of the n-bit value v, MSB first; cs_n stays low.
  task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] miso_bits);
    logic m;
    miso_bits = '0;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i], m);
      miso_bits = {miso_bits[30:0], m};
    end
  endtask

  task automatic check_pulses(input string name, input int v0, input int e0,
                              input int exp_v, input int exp_e);
    tests_run++;
    if ((n_valid - v0) !== exp_v) begin
      tests_failed++;
      $display("FAIL %s cmd_valid cycles: got %0d expected %0d", name, n_valid - v0, exp_v);
    end
    tests_run++;
    if ((n_err - e0) !== exp_e) begin
      tests_failed++;
      $display("FAIL %s frame_err cycles: got %0d expected %0d", name, n_err - e0, exp_e);
    end
  endtask

  task automatic check_words(input string name, input logic [7:0] c, input logic [15:0] d);
    tests_run++;
    if (bus.cmd_word !== c) begin
      tests_failed++;
      $display("FAIL %s cmd_word: got %h expected %h", name, bus.cmd_word, c);
    end
    tests_run++;
    if (bus.data_word !== d) begin
      tests_failed++;
      $display("FAIL %s data_word: got %h expected %h", name, bus.data_word, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_words("reset", 8'h00, 16'h0000);
    tests_run++;
    if (bus.cmd_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.spi_miso !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset strobes/miso: got %b%b%b expected 000",
               bus.cmd_valid, bus.frame_err, bus.spi_miso);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h00A5_1234, 24, mb);
    cs_end();
    check_pulses("good", v0, e0, 1, 0);
    check_words("good", 8'hA5, 16'h1234);
    tests_run++;
    if (mb[23:0] !== 24'h0) begin
      tests_failed++;
      $display("FAIL good miso after reset: got %h expected 000000", mb[23:0]);
    end
  endtask

  task automatic test_short_frame();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h0012_3456, 23, mb);
    cs_end();
    check_pulses("short", v0, e0, 0, 1);
    check_words("short", 8'hA5, 16'h1234);
  endtask

  task automatic test_overrun();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h03FF_FFFF, 26, mb);
    repeat (2) @(negedge clk);
    tests_run++;
    if (dut.r_state !== ST_OVERRUN) begin
      tests_failed++;
      $display("FAIL overrun state: got %0d expected %0d", dut.r_state, ST_OVERRUN);
    end
    cs_end();
    check_pulses("overrun", v0, e0, 0, 1);
    check_words("overrun", 8'hA5, 16'h1234);
  endtask

  task automatic test_miso_echo();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h00A5_1234, 24, mb);
    cs_end();
    cs_start();
    send_bits(32'h000F_0001, 24, mb);
    cs_end();
    tests_run++;
    if (mb[23:16] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL echo miso cmd bits: got %h expected a5", mb[23:16]);
    end
    tests_run++;
    if (mb[15:0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL echo miso tail: got %h expected 0000", mb[15:0]);
    end
    check_pulses("echo", v0, e0, 2, 0);
    check_words("echo", 8'h0F, 16'h0001);
  endtask

  task automatic test_reset_abort();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h0000_03CB, 12, mb);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_words("abort in reset", 8'h00, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(32'h0000_000E, 4, mb);
    cs_end();
    check_pulses("abort", v0, e0, 0, 0);
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h003C_BEEF, 24, mb);
    cs_end();
    check_pulses("after abort", v0, e0, 1, 0);
    check_words("after abort", 8'h3C, 16'hBEEF);
  endtask

  task automatic test_idle_sck();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 10; i++) begin
      bus.spi_mosi = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (dut.r_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL idle sck state: got %0d expected %0d", dut.r_state, ST_IDLE);
    end
    check_pulses("idle sck", v0, e0, 0, 0);
    check_words("idle sck", 8'h3C, 16'hBEEF);
  endtask

  task automatic test_coincident();
    int v0, e0;
    logic [31:0] mb;
    v0 = n_valid; e0 = n_err;
    cs_start();
    send_bits(32'h0055_AAAA, 23, mb);
    bus.spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_sck  = 1'b1;
    bus.spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    bus.spi_sck = 1'b0;
    repeat (6) @(negedge clk);
    check_pulses("coincident", v0, e0, 0, 1);
    check_words("coincident", 8'h3C, 16'hBEEF);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    n_valid = 0; n_err = 0; n_both = 0;
    rst_n        = 1'b0;
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (2) @(negedge clk);

    test_reset();
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_miso_echo();
    test_reset_abort();
    test_idle_sck();
    test_coincident();

    tests_run++;
    if (n_both !== 0) begin
      tests_failed++;
      $display("FAIL exclusive pulses: got %0d overlapping cycles expected 0", n_both);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_cmd_framer.md
SPI_CMD_FRAMER -- requirements
Module: spi_cmd_framer

Interface
REQ-001 Parameter DATAWORD_WIDTH, default 16: width of the data portion of a frame.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on each SPI input; legal values 2..3.
REQ-003 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active low.
REQ-005 Port spi_sck, input, 1: SPI clock, asynchronous to clk, mode 0.
REQ-006 Port spi_cs_n, input, 1: SPI chip select, active low, asynchronous.
REQ-007 Port spi_mosi, input, 1: SPI serial data in, MSB first.
REQ-008 Port spi_miso, output, 1: echo of the last accepted cmd_word, MSB first.
REQ-009 Port cmd_word, output, 8: command byte of the last accepted frame.
REQ-010 Port data_word, output, DATAWORD_WIDTH: data field of the last accepted frame.
REQ-011 Port cmd_valid, output, 1: one-clk pulse marking a new cmd_word/data_word pair.
REQ-012 Port frame_err, output, 1: one-clk pulse marking a rejected frame.

Function
REQ-013 All three SPI inputs SHALL pass through SYNC_STAGES flops before any use; edge detection on synced sck and cs_n SHALL use one extra history flop.
REQ-014 States SHALL be IDLE, SHIFT and OVERRUN only.
REQ-015 IDLE -> SHIFT on a synced cs_n falling edge; bit counter cleared, shift register cleared.
REQ-016 In SHIFT, each synced sck rising edge SHALL shift synced mosi into the LSB of a (8+DATAWORD_WIDTH)-bit shift register and increment the bit counter.
REQ-017 SHIFT -> OVERRUN on an sck rising edge when the counter already equals 8+DATAWORD_WIDTH; extra bits SHALL NOT alter the shift register.
REQ-018 On a synced cs_n rising edge in SHIFT with counter == 8+DATAWORD_WIDTH: load cmd_word = shift[top 8], data_word = shift[low DATAWORD_WIDTH]; pulse cmd_valid in the following clk cycle; go IDLE.
REQ-019 On a synced cs_n rising edge in SHIFT with counter != 8+DATAWORD_WIDTH, or in OVERRUN: outputs unchanged, pulse frame_err in the following clk cycle, go IDLE.
REQ-020 cmd_valid and frame_err SHALL never both be high, and each SHALL be high for exactly one clk cycle per frame.
REQ-021 cmd_word/data_word SHALL change only in the cycle cmd_valid rises and hold otherwise.
REQ-022 sck edges while cs_n is high (synced) SHALL be ignored.
REQ-023 If sck rising and cs_n rising edges are detected in the same clk cycle, the cs_n edge SHALL take priority and the sck edge is discarded.
REQ-024 spi_miso SHALL present bit 7 of the echo register at frame start and advance one bit on each synced sck falling edge in SHIFT; after 8 bits it SHALL drive 0.
REQ-025 The echo register SHALL load from cmd_word at each IDLE -> SHIFT transition.
REQ-026 The bit counter SHALL be sized to hold 8+DATAWORD_WIDTH+1 without wrap-around.

Reset
REQ-027 On rst_n low, state SHALL be IDLE, and all counters, shift, echo and synchronizer flops, cmd_word, data_word, cmd_valid, frame_err and spi_miso SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame without cmd_valid or frame_err; after release, a frame SHALL begin only on a fresh cs_n falling edge.

Structure
REQ-029 The frame length constant (8+DATAWORD_WIDTH) and the state encoding SHALL live in the shared project package alongside the command bit assignments.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_ff, with parameter STAGES, instantiated once per SPI input.

Verification
REQ-031 24-bit frame cmd=0xA5, data=0x1234, with SCK at clk/8 -> one cmd_valid pulse, cmd_word=0xA5, data_word=0x1234, frame_err never high.
REQ-032 Frame of 23 bits -> frame_err pulse, cmd_word/data_word keep their previous values, no cmd_valid.
REQ-033 Frame of 26 bits -> OVERRUN is entered, then a frame_err pulse on cs_n rise, and the outputs are unchanged.
REQ-034 Frame 0xA5/0x1234 followed by frame 0x0F/0x0001 -> spi_miso during the first 8 SCKs of frame two reads 0xA5.
REQ-035 rst_n pulsed low after 12 bits, then a clean frame 0x3C/0xBEEF -> no pulse for the aborted frame, then cmd_valid with 0x3C/0xBEEF.
REQ-036 SCK toggling with cs_n high, and final SCK edge coincident with cs_n rise -> the toggles are ignored, and the coincident case yields frame_err (23 bits counted).
